// File: rtl/tanh_sar_inverse_pkg.sv
// Shared types and constants for the tanh inverse (atanh-direction) search block.
//   state_t  : controller states IDLE -> SEARCH -> CHECK -> DONE
//   TANH_W   : code width the forward model is defined for
//   FWD_LUT  : reference forward table x -> y of the approximate tanh circuit
package tanh_inv_pkg;

  localparam int TANH_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Forward model as a table. The gate network in tanh_fwd_lut must agree with it.
  localparam logic [TANH_W-1:0] FWD_LUT [16] = '{
    4'd0, 4'd3, 4'd12, 4'd3, 4'd0, 4'd3, 4'd12, 4'd15,
    4'd0, 4'd3, 4'd12, 4'd3, 4'd12, 4'd3, 4'd12, 4'd15
  };

endpackage

// File: rtl/tanh_sar_inverse_if.sv
// Valid/ready bundle for the tanh inverse block.
//   in_valid/in_ready/in_y            : target code from the producer
//   out_valid/out_ready/out_x/out_exact : recovered code to the consumer
// master = producer/consumer side (testbench or surrounding logic), slave = the block.
interface tanh_sar_inverse_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic             out_exact;

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_x, out_exact
  );

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_x, out_exact
  );
endinterface

// File: rtl/tanh_fwd_lut.sv
// Combinational copy of the approximate 4-bit tanh gate network.
//   x : input code
//   y : forward output, y[1:0] = {x0,x0}, y[3:2] = {n,n}
// Non-monotonic in x; the inverse search relies on that being reproduced exactly.
module tanh_fwd_lut
  import tanh_inv_pkg::*;
(
  input  logic [TANH_W-1:0] x,
  output logic [TANH_W-1:0] y
);
  logic n;

  // Upper pair is set for "large" codes, except odd codes unless both x2 and x1 are set.
  assign n = ((x[3] & x[2]) | x[1]) & ~(x[0] & ~(x[2] & x[1]));
  assign y = {n, n, x[0], x[0]};
endmodule

// File: rtl/tanh_sar_inverse.sv
// Successive-approximation inverse of the approximate tanh forward model.
// Given target y, builds x MSB-first: a trial bit is kept when fwd(trial) <= y.
// The search is greedy; out_exact flags whether fwd(out_x) hits y exactly.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of tanh_sar_inverse_if (in_* target, out_* result)
// One transaction in flight; in_ready only in IDLE.
module tanh_sar_inverse
  import tanh_inv_pkg::*;
#(
  parameter int WIDTH    = TANH_W,  // only TANH_W is supported by the forward model
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  tanh_sar_inverse_if.slave  bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, acc_q, x_q;
  logic [BW-1:0]    bit_q;
  logic             exact_q;

  logic [WIDTH-1:0] onehot, trial, fwd_x, fwd_y;
  logic             accept, done_hs, keep, last_bit;

  assign accept  = bus.in_valid & bus.in_ready;
  assign done_hs = bus.out_valid & bus.out_ready;

  always_comb begin
    onehot        = '0;
    onehot[bit_q] = 1'b1;
  end

  assign trial    = acc_q | onehot;
  assign last_bit = (bit_q == '0);

  // Single forward instance: probes the trial while searching, the final acc in CHECK.
  assign fwd_x = (state_q == CHECK) ? acc_q : trial;

  tanh_fwd_lut u_fwd (
    .x (fwd_x),
    .y (fwd_y)
  );

  assign keep = (fwd_y <= y_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = SEARCH;
      SEARCH:  if (last_bit) state_d = CHECK_EN ? CHECK : DONE;
      CHECK:                 state_d = DONE;
      DONE:    if (done_hs)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Outputs; in_ready is held low while reset is asserted.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && rst_n;
    bus.out_valid = (state_q == DONE);
    bus.out_x     = x_q;
    bus.out_exact = exact_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      x_q     <= '0;
      exact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          y_q   <= bus.in_y;
          acc_q <= '0;
          bit_q <= BW'(WIDTH - 1);
        end
        SEARCH: begin
          if (keep)      acc_q <= trial;
          if (!last_bit) bit_q <= bit_q - 1'b1;
          // Without a CHECK cycle the result is taken straight from the last trial.
          if (last_bit && !CHECK_EN) x_q <= keep ? trial : acc_q;
        end
        CHECK: begin
          x_q     <= acc_q;
          exact_q <= CHECK_EN && (fwd_y == y_q);
        end
        default: ;
      endcase
    end
  end

  // Gate network must match the reference table whenever it is being used.
  a_fwd_matches_lut: assert property (@(posedge clk) disable iff (!rst_n)
    fwd_y == FWD_LUT[fwd_x]);

endmodule
